// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state and one extra bit per frame.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;
  localparam int DATA_BITS    = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts sys_clk cycles while enabled, pulses bit_end on the last cycle of a bit.
// Combinational bit_end, no backpressure; clr holds the count at zero.
module uart_baud_cnt #(
  parameter int BIT_CYC = 10
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding buffer; tx goes low one cycle after accept.
// Requests beyond the buffer are dropped with a tx_ovf pulse; UART_TX_PARITY_EN adds even parity.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_ovf
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;

  state_t     state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic [7:0] buf_dat;
  logic       buf_vld;
  logic       bit_end;
  logic       stop_end;
`ifdef UART_TX_PARITY_EN
  logic       par_bit;
`endif

  assign stop_end = (state == STOP) && bit_end;

  uart_baud_cnt #(
    .BIT_CYC (BIT_CYC)
  ) u_baud_cnt (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      (state != IDLE),
    .clr     (state == IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      buf_dat   <= '0;
      buf_vld   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_ovf    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      tx_ovf <= 1'b0;

      // A request in the last stop cycle with an empty buffer is started directly by STOP below.
      if (tx_en && state != IDLE) begin
        if (buf_vld) begin
          tx_ovf <= 1'b1;
        end else if (!stop_end) begin
          buf_dat <= tx_data;
          buf_vld <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (tx_en) begin
            shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_bit   <= ^tx_data;
`endif
            state     <= START;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= par_bit;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (buf_vld) begin
              shift_reg <= buf_dat;
`ifdef UART_TX_PARITY_EN
              par_bit   <= ^buf_dat;
`endif
              buf_vld   <= 1'b0;
              state     <= START;
              tx        <= 1'b0;
            end else if (tx_en) begin
              shift_reg <= tx_data;
`ifdef UART_TX_PARITY_EN
              par_bit   <= ^tx_data;
`endif
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, giving the serial bit rate.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: byte to send, sampled when tx_en=1.
REQ-006 The block SHALL have port tx_en, input, 1 bit: send request, one byte per cycle high.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: a frame is in progress or a byte is pending.
REQ-009 The block SHALL have port tx_ovf, output, 1 bit: one-cycle pulse when a request is dropped.

Function
REQ-010 The block SHALL use BIT_CYC = CLK_FREQ/BAUD (integer division) sys_clk cycles per serial bit.
REQ-011 The block SHALL use a frame of start(0), D0..D7 LSB first, optional parity (REQ-022), and stop(1).
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-013 Transitions SHALL be: IDLE->START on accept; START->DATA, DATA->DATA while bit index<7, DATA->PARITY/STOP, and PARITY->STOP, each after BIT_CYC cycles; STOP->START at end of stop if a byte is pending, else STOP->IDLE.
REQ-014 When tx_en=1 in IDLE, the block SHALL load tx_data into the shift register, and tx SHALL go low on the next rising edge (1-cycle latency).
REQ-015 tx_busy SHALL rise on the edge after accept and remain high until the last stop-bit cycle completes with no byte pending.
REQ-016 A tx_en=1 while tx_busy=1 with the one-deep holding buffer empty SHALL store tx_data in the buffer.
REQ-017 A tx_en=1 while the buffer is full SHALL drop the byte, leave the buffer unchanged, and pulse tx_ovf for exactly one cycle.
REQ-018 A pending byte SHALL start transmission in the cycle immediately after the stop bit ends, with zero idle gap.
REQ-019 A tx_en=1 in the final stop-bit cycle with the buffer empty SHALL behave as a pending byte, starting its start bit on the next edge.
REQ-020 The bit-cycle counter SHALL wrap from BIT_CYC-1 to 0, and the bit index SHALL wrap from 7 to 0.

Reset
REQ-021 While rst_n=0 the block SHALL force, asynchronously and including mid-frame, tx=1, tx_busy=0 and tx_ovf=0, state=IDLE, all counters to 0, and the buffer empty; the block SHALL be idle on the first edge after release.

Configuration
REQ-022 Macro UART_TX_PARITY_EN SHALL control the parity feature.
- Defined: the block SHALL insert an even-parity bit (XOR of D0..D7) after D7, using the PARITY state, for a frame of 11*BIT_CYC cycles.
- Undefined: the PARITY state and its logic SHALL be absent, for a frame of 10*BIT_CYC cycles.

Structure
REQ-023 Package uart_pkg SHALL hold the state enum type, default CLK_FREQ/BAUD constants, and the frame-length constants.
REQ-024 Bit timing SHALL live in sub-module uart_baud_cnt, which provides the counter plus a bit_end pulse with enable/clear inputs.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, BIT_CYC=10)
REQ-025 Case: tx_en with 0x55 in IDLE.
- tx SHALL be low for 10 cycles starting 1 cycle after accept, then carry 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high.
- tx_busy SHALL be high for 100 cycles.
REQ-026 Case: 0xA3 accepted, then 0x0F at cycle 30.
- The 0x0F start bit SHALL begin at cycle 101.
- tx_busy SHALL be high continuously for 200 cycles.
REQ-027 Case: three tx_en during one frame.
- The second byte SHALL be buffered.
- The third SHALL be dropped with a one-cycle tx_ovf pulse.
- Exactly two frames SHALL appear on tx.
REQ-028 Case: rst_n low mid-D3.
- tx=1 and tx_busy=0 SHALL hold immediately without waiting for a clock.
- After release, tx_en with 0x81 SHALL give a correct frame.
REQ-029 Case: tx_en with 0x3C in the final stop-bit cycle.
- The start bit SHALL follow on the next edge.
- tx_busy SHALL show no gap.
REQ-030 Case: UART_TX_PARITY_EN defined, 0x07 sent.
- The parity bit SHALL be 1.
- The frame SHALL be 110 cycles.
